alu_op_sequencer: RTL and testbench

Multi-cycle issue/writeback controller that drives the 32-bit ALU datapath. It accepts decoded register-register operations over a valid/ready handshake and reads operands from an internal 8×32 register file. It drives the ALU's A, B and control inputs, captures Result/Zero and writes the result back. It sits between instruction decode and the combinational ALU and is the initiating side of the ALU operand/control interface.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/regfile_8x32.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, sequencer state encoding and legality check.
// Used by the ALU, the op sequencer and their benches.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_e;

    function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: is_legal_ctrl = 1'b1;
            default:                                    is_legal_ctrl = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_8x32.sv
// Register file: two asynchronous read ports, write-back and direct-load write ports.
// r0 reads as zero; write-back beats a direct load to the same register.
module regfile_8x32 #(
    parameter int NREGS = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      ra1,
    input  logic [2:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wb_en,
    input  logic [2:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_en,
    input  logic [2:0]      ld_addr,
    input  logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] regs [NREGS];

    assign rd1 = (ra1 == 3'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 3'd0) ? '0 : regs[ra2];

    // Entry 0 is never written, so it stays at its cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_en && wb_addr == 3'(i))
                    regs[i] <= wb_data;
                else if (ld_en && ld_addr == 3'(i))
                    regs[i] <= ld_data;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback controller for the combinational ALU: IDLE -> READ -> EXEC -> WB.
// Valid/ready: an operation transfers on a rising edge where in_valid and in_ready are both 1.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_ctrl,
    input  logic [2:0]      in_rd,
    input  logic [2:0]      in_rs1,
    input  logic [2:0]      in_rs2,
    input  logic            ld_en,
    input  logic [2:0]      ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            done,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_READ = READ;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_WB   = WB;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [3:0]      ctrl_q;
    logic [2:0]      rd_q;
    logic [2:0]      rs1_q;
    logic [2:0]      rs2_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            legal;
    logic            hs;
    logic            wb_en;

    assign hs    = in_valid & in_ready;
    assign legal = is_legal_ctrl(ctrl_q);
    assign wb_en = (state == ST_WB) && legal && (rd_q != 3'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hs) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == ST_IDLE);
            done     <= (state == ST_WB);
            err      <= (state == ST_WB) && !legal;
            if (hs) begin
                ctrl_q <= in_ctrl;
                rd_q   <= in_rd;
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
            end
            // ALU drive registers load once per operation and hold until the next one.
            if (state == ST_READ) begin
                alu_a    <= rdata1;
                alu_b    <= rdata2;
                alu_ctrl <= ctrl_q;
            end
            if (state == ST_EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
            if (state == ST_WB) begin
                out_result <= legal ? res_q : '0;
                out_zero   <= legal ? zero_q : 1'b1;
            end
        end
    end

    regfile_8x32 #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (rs1_q),
        .ra2     (rs2_q),
        .rd1     (rdata1),
        .rd2     (rdata2),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (res_q),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the operand interface, vector table,
// scoreboard queue checked on every done pulse, and hand-written corner sequences.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_ctrl = '0;
    logic [2:0]  in_rd = '0;
    logic [2:0]  in_rs1 = '0;
    logic [2:0]  in_rs2 = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic [31:0] out_result;
    logic        out_zero;
    logic        err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_vec = -1;

    // {err, zero, result}
    logic [33:0] exp_q[$];
    int          hs_q[$];

    typedef struct {
        bit          do_ld;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [31:0] er;
        logic        ez;
        logic        ee;
    } vec_t;

    vec_t vt[14];

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done       (done),
        .out_result (out_result),
        .out_zero   (out_zero),
        .err        (err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU; illegal codes return junk so the sequencer must mask them.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_ctrl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got %h want %h", name, cur_vec, act, exp);
        end
    endfunction

    // scoreboard: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [33:0] e;
                int          h;
                e = exp_q.pop_front();
                h = hs_q.pop_front();
                chk("out_result", out_result, e[31:0]);
                chk("out_zero", 32'(out_zero), 32'(e[32]));
                chk("err", 32'(err), 32'(e[33]));
                chk("latency", 32'(cyc - h), 32'd3);
            end
        end else if (rst_n && err) begin
            chk("err_without_done", 32'd1, 32'd0);
        end
    end

    // driver tasks
    task automatic load(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic start_op(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [31:0] er, input logic ez,
                            input logic ee, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        @(posedge clk);
        exp_q.push_back({ee, ez, er});
        #1;
        hs_q.push_back(cyc);
        @(negedge clk);
        chk("busy_ready", 32'(in_ready), 32'd0);
        if (hold) begin
            in_ctrl = 4'($urandom_range(0, 15));
            in_rd   = 3'($urandom_range(1, 7));
            in_rs1  = 3'($urandom_range(0, 7));
            in_rs2  = 3'($urandom_range(0, 7));
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 12; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            if (done) in_valid = 1'b0;
            #1;
        end
        in_valid = 1'b0;
        chk("op_completed", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        hs_q.delete();
    endtask

    task automatic run_op(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [31:0] er, input logic ez,
                          input logic ee);
        start_op(c, rd, rs1, rs2, er, ez, ee, 1'b0);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 32'd10,        32'd5,         ALU_ADD, 3'd3, 3'd1, 3'd2, 32'd15,        1'b0, 1'b0};
        vt[1]  = '{1'b0, 32'd0,         32'd0,         ALU_OR,  3'd0, 3'd3, 3'd0, 32'd15,        1'b0, 1'b0};
        vt[2]  = '{1'b1, 32'd15,        32'd15,        ALU_SUB, 3'd4, 3'd1, 3'd2, 32'd0,         1'b1, 1'b0};
        vt[3]  = '{1'b0, 32'd0,         32'd0,         ALU_ADD, 3'd0, 3'd4, 3'd3, 32'd15,        1'b0, 1'b0};
        vt[4]  = '{1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, ALU_AND, 3'd6, 3'd1, 3'd2, 32'd0,         1'b1, 1'b0};
        vt[5]  = '{1'b0, 32'd0,         32'd0,         ALU_OR,  3'd7, 3'd1, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 32'hFFFF_FFFB, 32'd3,         ALU_SLT, 3'd6, 3'd1, 3'd2, 32'd1,         1'b0, 1'b0};
        vt[7]  = '{1'b0, 32'd0,         32'd0,         ALU_SLT, 3'd6, 3'd2, 3'd1, 32'd0,         1'b1, 1'b0};
        vt[8]  = '{1'b1, 32'd10,        32'd20,        ALU_SLT, 3'd6, 3'd1, 3'd2, 32'd1,         1'b0, 1'b0};
        vt[9]  = '{1'b1, 32'hFFFF_FFFF, 32'd2,         ALU_ADD, 3'd6, 3'd1, 3'd2, 32'd1,         1'b0, 1'b0};
        vt[10] = '{1'b1, 32'd3,         32'd5,         ALU_SUB, 3'd6, 3'd1, 3'd2, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[11] = '{1'b0, 32'd0,         32'd0,         ALU_ADD, 3'd0, 3'd1, 3'd2, 32'd8,         1'b0, 1'b0};
        vt[12] = '{1'b0, 32'd0,         32'd0,         ALU_OR,  3'd6, 3'd0, 3'd0, 32'd0,         1'b1, 1'b0};
        vt[13] = '{1'b0, 32'd0,         32'd0,         4'b0011, 3'd6, 3'd1, 3'd2, 32'd0,         1'b1, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // vector table
        for (int i = 0; i < 14; i++) begin
            cur_vec = i;
            if (vt[i].do_ld) begin
                load(3'd1, vt[i].a);
                load(3'd2, vt[i].b);
            end
            run_op(vt[i].ctrl, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].er, vt[i].ez, vt[i].ee);
        end

        // illegal code leaves rd untouched
        cur_vec = 100;
        load(3'd5, 32'd77);
        load(3'd1, 32'd1);
        load(3'd2, 32'd2);
        run_op(4'b1111, 3'd5, 3'd1, 3'd2, 32'd0, 1'b1, 1'b1);
        run_op(ALU_OR, 3'd0, 3'd5, 3'd0, 32'd77, 1'b0, 1'b0);

        // in_valid held with changing fields while busy: one operation only
        cur_vec = 101;
        start_op(ALU_ADD, 3'd0, 3'd1, 3'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        wait_idle();
        repeat (6) @(negedge clk);

        // direct load and write-back to the same register on the same edge
        cur_vec = 102;
        load(3'd1, 32'd10);
        load(3'd2, 32'd5);
        start_op(ALU_ADD, 3'd3, 3'd1, 3'd2, 32'd15, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("exec_alu_a", alu_a, 32'd10);
        chk("exec_alu_b", alu_b, 32'd5);
        chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 3'd3;
        ld_data = 32'd999;
        @(negedge clk);
        ld_en = 1'b0;
        wait_idle();
        run_op(ALU_OR, 3'd0, 3'd3, 3'd0, 32'd15, 1'b0, 1'b0);

        // reset pulsed during EXEC
        cur_vec = 103;
        load(3'd1, 32'd7);
        load(3'd2, 32'd9);
        start_op(ALU_ADD, 3'd3, 3'd1, 3'd2, 32'd16, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        hs_q.delete();
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        run_op(ALU_OR, 3'd0, 3'd1, 3'd2, 32'd0, 1'b1, 1'b0);
        run_op(ALU_OR, 3'd0, 3'd3, 3'd5, 32'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
